spi_flash_responder: RTL and testbench

Synthesizable SPI NOR-flash device model that answers the serial flash controller from the device side of the bus (SPI mode 0, MSB first). It receives chip select, serial clock and command/address/data, and returns read and status data. It holds a small erasable byte array and emulates write-enable, program, erase and busy semantics. It is used on-chip and in benches as the flash end of the interface, so controller and test-top logic can run without a physical part.

---
 rtl/spi_flash_responder_if.sv | 19 +
 rtl/spi_flash_responder.sv | 241 ++++++++++++++++++++++++
 tb/tb_spi_flash_responder.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_flash_responder_if.sv
// SPI flash bus between a serial flash controller (master) and the
// flash device model (slave).
//   ncs   : chip select, active low (controller -> device)
//   dclk  : serial clock, idles low (controller -> device)
//   d_in  : serial data to device (controller's D)
//   q_out : serial data to controller (controller's Q)
//   busy  : device status WIP mirror
//   wel   : device status WEL mirror
interface spi_flash_responder_if;
  logic ncs;
  logic dclk;
  logic d_in;
  logic q_out;
  logic busy;
  logic wel;

  modport master (output ncs, dclk, d_in, input q_out, busy, wel);
  modport slave  (input ncs, dclk, d_in, output q_out, busy, wel);
endinterface

// File: rtl/spi_flash_responder.sv
// SPI NOR-flash device model (mode 0, MSB first) with a small erasable
// byte array. Supports WREN, WRDI, RDSR, READ, PP, SE and BE with
// write-enable latch, busy (WIP) timing and a power-up erase sweep.
// Ports:
//   clk   : system clock, all logic on rising edge
//   reset : synchronous, active-high
//   bus   : slave side of spi_flash_responder_if (ncs/dclk/d_in in,
//           q_out/busy/wel out); bus inputs are asynchronous to clk
module spi_flash_responder #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned SECTOR_W = 4,
  parameter int unsigned PP_BUSY  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  spi_flash_responder_if.slave  bus
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned SR_W  = (ADDR_W > 8) ? ADDR_W : 8;
  localparam int unsigned PPC_W = $clog2(PP_BUSY + 1);
  localparam logic [ADDR_W:0] SWP_ALL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] SWP_SEC = (ADDR_W + 1)'(1 << SECTOR_W);

  localparam logic [7:0] OP_WREN = 8'h06;
  localparam logic [7:0] OP_WRDI = 8'h04;
  localparam logic [7:0] OP_RDSR = 8'h05;
  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_PP   = 8'h02;
  localparam logic [7:0] OP_SE   = 8'hD8;
  localparam logic [7:0] OP_BE   = 8'hC7;

  typedef enum logic [1:0] {ST_IDLE, ST_SWEEP, ST_PPWAIT} state_t;
  typedef enum logic [2:0] {
    CMD_NONE, CMD_WREN, CMD_WRDI, CMD_RDSR, CMD_READ, CMD_PP, CMD_SE, CMD_BE
  } cmd_t;

  logic [2:0]        r_ncs_s;
  logic [2:0]        r_dclk_s;
  logic [1:0]        r_din_s;
  logic [5:0]        r_bitcnt;
  logic              r_extra;
  logic [SR_W-1:0]   r_sr;
  cmd_t              r_cmd;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_osr;
  logic              r_q;
  logic              r_wel;
  logic              r_wip;
  logic              r_pp_wrote;
  state_t            r_state;
  logic [ADDR_W-1:0] r_swp_addr;
  logic [ADDR_W:0]   r_swp_left;
  logic [PPC_W-1:0]  r_pp_cnt;
  logic [7:0]        r_mem [DEPTH];

  logic              w_ncs_low, w_ncs_rise, w_rise, w_fall, w_pp_byte;
  logic [SR_W-1:0]   w_sr_next;
  logic [7:0]        w_mem_rd;
  logic              w_load_en;
  logic [7:0]        w_load_byte;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [7:0]        w_wdata;

  assign w_ncs_low  = ~r_ncs_s[1];
  assign w_ncs_rise = r_ncs_s[1] & ~r_ncs_s[2];
  assign w_rise     = w_ncs_low & r_dclk_s[1] & ~r_dclk_s[2];
  assign w_fall     = w_ncs_low & ~r_dclk_s[1] & r_dclk_s[2];
  assign w_sr_next  = {r_sr[SR_W-2:0], r_din_s[1]};
  assign w_mem_rd   = r_mem[r_addr];
  // Bit counter runs 1..39, then folds back to 32 so every data byte ends
  // on count 39; r_extra marks that the fold happened (more than 32 bits).
  assign w_pp_byte  = w_rise && (r_cmd == CMD_PP) && (r_bitcnt == 6'd39);

  assign bus.q_out = r_q;
  assign bus.busy  = r_wip;
  assign bus.wel   = r_wel;

  // Output byte reload at each byte boundary of RDSR / READ data phase.
  always_comb begin
    w_load_en   = 1'b0;
    w_load_byte = w_mem_rd;
    if (r_bitcnt[2:0] == 3'd0) begin
      if (r_cmd == CMD_RDSR) begin
        w_load_en   = 1'b1;
        w_load_byte = {6'b0, r_wel, r_wip};
      end else if (r_cmd == CMD_READ && r_bitcnt >= 6'd32) begin
        w_load_en = 1'b1;
      end
    end
  end

  // Sweep and program never overlap: PP is only decoded while WIP is clear.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_swp_addr;
    w_wdata = 8'hFF;
    if (!reset) begin
      if (r_state == ST_SWEEP && r_swp_left != '0) begin
        w_we = 1'b1;
      end else if (w_pp_byte) begin
        w_we    = 1'b1;
        w_waddr = r_addr;
        w_wdata = w_mem_rd & w_sr_next[7:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ncs_s    <= '1;
      r_dclk_s   <= '0;
      r_din_s    <= '0;
      r_bitcnt   <= '0;
      r_extra    <= 1'b0;
      r_sr       <= '0;
      r_cmd      <= CMD_NONE;
      r_addr     <= '0;
      r_osr      <= '0;
      r_q        <= 1'b0;
      r_wel      <= 1'b0;
      r_wip      <= 1'b1;
      r_pp_wrote <= 1'b0;
      r_state    <= ST_SWEEP;
      r_swp_addr <= '0;
      r_swp_left <= SWP_ALL;
      r_pp_cnt   <= '0;
    end else begin
      r_ncs_s  <= {r_ncs_s[1:0], bus.ncs};
      r_dclk_s <= {r_dclk_s[1:0], bus.dclk};
      r_din_s  <= {r_din_s[0], bus.d_in};

      if (!w_ncs_low) begin
        r_bitcnt   <= '0;
        r_extra    <= 1'b0;
        r_sr       <= '0;
        r_cmd      <= CMD_NONE;
        r_osr      <= '0;
        r_q        <= 1'b0;
        r_pp_wrote <= 1'b0;
      end else if (w_rise) begin
        r_sr <= w_sr_next;
        if (r_bitcnt == 6'd39) begin
          r_bitcnt <= 6'd32;
          r_extra  <= 1'b1;
        end else begin
          r_bitcnt <= r_bitcnt + 6'd1;
        end
        if (r_bitcnt == 6'd7) begin
          r_cmd <= CMD_NONE;
          case (w_sr_next[7:0])
            OP_RDSR: r_cmd <= CMD_RDSR;
            OP_WREN: if (!r_wip) r_cmd <= CMD_WREN;
            OP_WRDI: if (!r_wip) r_cmd <= CMD_WRDI;
            OP_READ: if (!r_wip) r_cmd <= CMD_READ;
            OP_PP:   if (!r_wip && r_wel) r_cmd <= CMD_PP;
            OP_SE:   if (!r_wip && r_wel) r_cmd <= CMD_SE;
            OP_BE:   if (!r_wip && r_wel) r_cmd <= CMD_BE;
            default: r_cmd <= CMD_NONE;
          endcase
        end
        if (r_bitcnt == 6'd31) begin
          r_addr <= w_sr_next[ADDR_W-1:0];
        end else if (w_pp_byte) begin
          r_addr     <= r_addr + ADDR_W'(1);
          r_pp_wrote <= 1'b1;
        end
      end else if (w_fall) begin
        if (w_load_en) begin
          r_q   <= w_load_byte[7];
          r_osr <= {w_load_byte[6:0], 1'b0};
          if (r_cmd == CMD_READ) r_addr <= r_addr + ADDR_W'(1);
        end else begin
          r_q   <= r_osr[7];
          r_osr <= {r_osr[6:0], 1'b0};
        end
      end

      case (r_state)
        ST_SWEEP: begin
          if (r_swp_left == '0) begin
            r_state <= ST_IDLE;
            r_wip   <= 1'b0;
          end else begin
            r_swp_addr <= r_swp_addr + ADDR_W'(1);
            r_swp_left <= r_swp_left - (ADDR_W + 1)'(1);
          end
        end
        ST_PPWAIT: begin
          if (r_pp_cnt == '0) begin
            r_state <= ST_IDLE;
            r_wip   <= 1'b0;
          end else begin
            r_pp_cnt <= r_pp_cnt - PPC_W'(1);
          end
        end
        default: begin
          if (w_ncs_rise) begin
            case (r_cmd)
              CMD_WREN: if (r_bitcnt == 6'd8) r_wel <= 1'b1;
              CMD_WRDI: if (r_bitcnt == 6'd8) r_wel <= 1'b0;
              CMD_PP: begin
                if (r_pp_wrote) begin
                  r_wel    <= 1'b0;
                  r_wip    <= 1'b1;
                  r_state  <= ST_PPWAIT;
                  r_pp_cnt <= PPC_W'(PP_BUSY - 1);
                end
              end
              CMD_SE: begin
                if (r_bitcnt == 6'd32 && !r_extra) begin
                  r_wel      <= 1'b0;
                  r_wip      <= 1'b1;
                  r_state    <= ST_SWEEP;
                  r_swp_addr <= {r_addr[ADDR_W-1:SECTOR_W], SECTOR_W'(0)};
                  r_swp_left <= SWP_SEC;
                end
              end
              CMD_BE: begin
                if (r_bitcnt == 6'd8) begin
                  r_wel      <= 1'b0;
                  r_wip      <= 1'b1;
                  r_state    <= ST_SWEEP;
                  r_swp_addr <= '0;
                  r_swp_left <= SWP_ALL;
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Bench for spi_flash_responder: directed flash sequences plus randomized
// PP/READ/SE/RDSR traffic, checked against a byte-array model of the part.
module tb_spi_flash_responder;
  localparam int unsigned ADDR_W   = 8;
  localparam int unsigned SECTOR_W = 4;
  localparam int unsigned PP_BUSY  = 16;
  localparam int unsigned DEPTH    = 1 << ADDR_W;
  localparam int unsigned H        = 6;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  spi_flash_responder_if bus();

  spi_flash_responder #(.ADDR_W(ADDR_W), .SECTOR_W(SECTOR_W), .PP_BUSY(PP_BUSY)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_err    = 0;
  logic [7:0] m_mem [DEPTH];
  logic       m_wel;
  logic [7:0] pp_data [4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = 8'hFF;
    m_wel = 1'b0;
  endtask

  task automatic spi_bit(input logic b, output logic q);
    @(negedge clk);
    bus.d_in = b;
    repeat (H) @(negedge clk);
    q = bus.q_out;
    bus.dclk = 1'b1;
    repeat (H) @(negedge clk);
    bus.dclk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic q;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], q);
      rx[i] = q;
    end
  endtask

  task automatic send_addr(input logic [23:0] a);
    logic [7:0] rx;
    spi_byte(a[23:16], rx);
    spi_byte(a[15:8], rx);
    spi_byte(a[7:0], rx);
  endtask

  task automatic cs_begin();
    @(negedge clk);
    bus.ncs = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic cs_end();
    repeat (4) @(negedge clk);
    bus.ncs = 1'b1;
  endtask

  // Counts clk cycles with busy high following ncs rise; bounded.
  task automatic measure_busy(output int n);
    bit done;
    done = 1'b0;
    n = 0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(posedge clk);
      #1;
      if (bus.busy) n++;
      else if (n > 0 || i >= 12) done = 1'b1;
    end
    check("busy_bound", done, 1'b1);
    repeat (6) @(negedge clk);
  endtask

  task automatic wait_reset_release(input string tag);
    int n;
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (bus.busy && n < 2000);
    check(tag, n, DEPTH + 1);
    model_reset();
    repeat (4) @(negedge clk);
  endtask

  task automatic cmd1(input logic [7:0] op, input string tag);
    logic [7:0] rx;
    int b;
    cs_begin();
    spi_byte(op, rx);
    cs_end();
    measure_busy(b);
    if (op == 8'h06) m_wel = 1'b1;
    if (op == 8'h04) m_wel = 1'b0;
    check({tag, "_busy"}, b, 0);
    check({tag, "_wel"}, bus.wel, m_wel);
  endtask

  task automatic do_read(input logic [23:0] a, input int n, input string tag);
    logic [7:0] rx, idx;
    cs_begin();
    spi_byte(8'h03, rx);
    send_addr(a);
    for (int i = 0; i < n; i++) begin
      spi_byte(8'h00, rx);
      idx = a[7:0] + 8'(i);
      check(tag, rx, m_mem[idx]);
    end
    cs_end();
    repeat (8) @(negedge clk);
  endtask

  task automatic do_pp(input logic [23:0] a, input int n, input string tag);
    logic [7:0] rx, idx;
    int b, exp_b;
    cs_begin();
    spi_byte(8'h02, rx);
    send_addr(a);
    for (int i = 0; i < n; i++) spi_byte(pp_data[i], rx);
    cs_end();
    measure_busy(b);
    exp_b = 0;
    if (m_wel && n > 0) begin
      exp_b = PP_BUSY;
      for (int i = 0; i < n; i++) begin
        idx = a[7:0] + 8'(i);
        m_mem[idx] = m_mem[idx] & pp_data[i];
      end
      m_wel = 1'b0;
    end
    check({tag, "_busy"}, b, exp_b);
    check({tag, "_wel"}, bus.wel, m_wel);
  endtask

  task automatic do_se(input logic [23:0] a, input string tag);
    logic [7:0] rx, base;
    int b, exp_b;
    cs_begin();
    spi_byte(8'hD8, rx);
    send_addr(a);
    cs_end();
    measure_busy(b);
    exp_b = 0;
    if (m_wel) begin
      exp_b = (1 << SECTOR_W) + 1;
      base  = {a[7:4], 4'h0};
      for (int i = 0; i < (1 << SECTOR_W); i++) m_mem[base + 8'(i)] = 8'hFF;
      m_wel = 1'b0;
    end
    check({tag, "_busy"}, b, exp_b);
    check({tag, "_wel"}, bus.wel, m_wel);
  endtask

  task automatic do_rdsr(input int n, input string tag);
    logic [7:0] rx;
    cs_begin();
    spi_byte(8'h05, rx);
    for (int i = 0; i < n; i++) begin
      spi_byte(8'h00, rx);
      check(tag, rx, {6'b0, m_wel, 1'b0});
    end
    cs_end();
    repeat (8) @(negedge clk);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] rx;
    logic [7:0] st [6];
    logic [23:0] a, pa;
    logic q;
    int b, rises;

    bus.ncs  = 1'b1;
    bus.dclk = 1'b0;
    bus.d_in = 1'b0;
    reset    = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rst_q", bus.q_out, 1'b0);
    check("rst_wel", bus.wel, 1'b0);
    check("rst_busy", bus.busy, 1'b1);
    wait_reset_release("init_busy_len");

    do_read(24'h000000, 4, "rd_init");

    cmd1(8'h06, "wren1");
    do_rdsr(2, "rdsr_wel");
    pp_data[0] = 8'h3C;
    do_pp(24'h000005, 1, "pp1");
    do_read(24'h000005, 1, "rd_pp1");

    pp_data[0] = 8'h0F;
    do_pp(24'h000005, 1, "pp_nowel");
    do_read(24'h000005, 1, "rd_nowel");
    cmd1(8'h06, "wren2");
    do_pp(24'h000005, 1, "pp_and");
    do_read(24'h000005, 1, "rd_and");

    cmd1(8'h06, "wren3");
    pp_data[0] = 8'h00;
    do_pp(24'h000012, 1, "pp12");
    cmd1(8'h06, "wren4");
    do_se(24'h000013, "se13");
    do_read(24'h000010, 16, "rd_sector");
    do_read(24'h000005, 1, "rd_outside");

    // Bulk erase with status polled inside one RDSR command.
    cmd1(8'h06, "wren5");
    cs_begin();
    spi_byte(8'hC7, rx);
    cs_end();
    model_reset();
    repeat (6) @(negedge clk);
    cs_begin();
    spi_byte(8'h05, rx);
    for (int i = 0; i < 6; i++) begin
      spi_byte(8'h00, st[i]);
      check("rdsr_be_upper", st[i][7:1], 7'h00);
    end
    cs_end();
    repeat (8) @(negedge clk);
    rises = 0;
    for (int i = 1; i < 6; i++) if (st[i] > st[i-1]) rises++;
    check("rdsr_be_first", st[0], 8'h01);
    check("rdsr_be_last", st[5], 8'h00);
    check("rdsr_be_mono", rises, 0);
    check("be_busy_done", bus.busy, 1'b0);
    do_read(24'h000005, 1, "rd_be");

    cmd1(8'h06, "wren6");
    pp_data[0] = 8'hA5;
    do_pp(24'h000000, 1, "pp_00");
    cmd1(8'h06, "wren7");
    pp_data[0] = 8'h5A;
    do_pp(24'h0000FF, 1, "pp_ff");
    do_read(24'h0000FF, 2, "rd_wrap");

    // PP aborted mid-address: no write, no busy, WEL kept.
    cmd1(8'h06, "wren8");
    cs_begin();
    spi_byte(8'h02, rx);
    pa = 24'h000040;
    for (int i = 23; i >= 12; i--) spi_bit(pa[i], q);
    cs_end();
    measure_busy(b);
    check("pp20_busy", b, 0);
    check("pp20_wel", bus.wel, m_wel);
    do_rdsr(1, "rdsr_pp20");
    do_read(24'h000040, 1, "rd_pp20");

    for (int it = 0; it < 14; it++) begin
      a = 24'($urandom());
      case ($urandom_range(0, 4))
        0: begin
          cmd1(8'h06, "rnd_wren");
          for (int i = 0; i < 4; i++) pp_data[i] = 8'($urandom());
          do_pp(a, $urandom_range(1, 3), "rnd_pp");
          do_read(a, 3, "rnd_rd_pp");
        end
        1: do_read(a, $urandom_range(1, 4), "rnd_rd");
        2: begin
          cmd1(8'h06, "rnd_wren_se");
          do_se(a, "rnd_se");
          do_read({a[23:4], 4'h0}, 2, "rnd_rd_se");
        end
        3: begin
          cmd1(8'h04, "rnd_wrdi");
          pp_data[0] = 8'h00;
          do_pp(a, 1, "rnd_pp_nowel");
          do_read(a, 1, "rnd_rd_nowel");
        end
        default: do_rdsr(2, "rnd_rdsr");
      endcase
    end

    // Reset during a transfer restarts everything, including the erase sweep.
    cmd1(8'h06, "wren9");
    cs_begin();
    spi_byte(8'h02, rx);
    for (int i = 0; i < 5; i++) spi_bit(1'b0, q);
    @(negedge clk);
    reset    = 1'b1;
    bus.ncs  = 1'b1;
    bus.dclk = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst2_wel", bus.wel, 1'b0);
    check("rst2_busy", bus.busy, 1'b1);
    wait_reset_release("rst2_busy_len");
    do_read(24'h0000FF, 2, "rd_after_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
